// File: rtl/dafx_host_sample_capture_pkg.sv
// Shared constants and snapshot word type for the DAFX host capture path.
// DAFX_CAPTURE_TIMESTAMP_EN widens each stored snapshot with a 32-bit index.
package dafx_host_sample_capture_pkg;

    localparam int AUDIO_WIDTH_C          = 24;
    localparam int NR_OF_CHANNELS_C       = 3;
    localparam int SYS_CLK_FREQUENCY_C    = 125_000_000;
    localparam int HOST_F_SAMPLING_C      = 10_000;
    localparam int SAMPLING_IRQ_COUNTER_C = SYS_CLK_FREQUENCY_C / HOST_F_SAMPLING_C;
    localparam int CAPTURE_FIFO_DEPTH_C   = 16;
    localparam int CAPTURE_TS_WIDTH_C     = 32;

`ifdef DAFX_CAPTURE_TIMESTAMP_EN
    localparam int CAPTURE_TS_BITS_C = CAPTURE_TS_WIDTH_C;
`else
    localparam int CAPTURE_TS_BITS_C = 0;
`endif

    typedef struct packed {
`ifdef DAFX_CAPTURE_TIMESTAMP_EN
        logic [CAPTURE_TS_WIDTH_C-1:0]                  timestamp;
`endif
        logic [NR_OF_CHANNELS_C*AUDIO_WIDTH_C-1:0]      samples;
    } capture_snapshot_t;

    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dafx_host_sample_capture_if.sv
// Host capture bus: sample inputs and control pulses in, popped snapshots and status out.
// master = sample source / host side, slave = capture block.
interface dafx_host_sample_capture_if #(
    parameter int AUDIO_WIDTH_P    = dafx_host_sample_capture_pkg::AUDIO_WIDTH_C,
    parameter int NR_OF_CHANNELS_P = dafx_host_sample_capture_pkg::NR_OF_CHANNELS_C,
    parameter int FIFO_DEPTH_P     = dafx_host_sample_capture_pkg::CAPTURE_FIFO_DEPTH_C
);
    logic [NR_OF_CHANNELS_P-1:0]               x_valid;
    logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] x_data;
    logic                                      cr_enable;
    logic                                      cr_clear;
    logic                                      cr_pop;
    logic                                      irq_ack;
    logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] rd_data;
    logic [dafx_host_sample_capture_pkg::CAPTURE_TS_WIDTH_C-1:0] rd_timestamp;
    logic                                      rd_valid;
    logic [$clog2(FIFO_DEPTH_P):0]             sr_fill;
    logic                                      sr_overflow;
    logic                                      irq;

    modport master (
        output x_valid, x_data, cr_enable, cr_clear, cr_pop, irq_ack,
        input  rd_data, rd_timestamp, rd_valid, sr_fill, sr_overflow, irq
    );

    modport slave (
        input  x_valid, x_data, cr_enable, cr_clear, cr_pop, irq_ack,
        output rd_data, rd_timestamp, rd_valid, sr_fill, sr_overflow, irq
    );
endinterface

// File: rtl/dafx_sample_fifo.sv
// Synchronous snapshot FIFO with registered read port and fill counter.
// Full/empty come from the fill count; a pop frees a slot for a same-cycle push.
module dafx_sample_fifo #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH_P-1:0]       i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH_P-1:0]       o_rdata,
    output logic                     o_rvalid,
    output logic [$clog2(DEPTH_P):0] o_fill,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_push_ok
);
    localparam int PTR_W_L = $clog2(DEPTH_P);

    logic [WIDTH_P-1:0] r_mem [DEPTH_P];
    logic [PTR_W_L-1:0] r_wr_ptr;
    logic [PTR_W_L-1:0] r_rd_ptr;
    logic [PTR_W_L:0]   r_fill;
    logic [WIDTH_P-1:0] r_rdata;
    logic               r_rvalid;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_empty   = (r_fill == '0);
    assign o_full    = (r_fill == (PTR_W_L+1)'(DEPTH_P));
    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && !i_clear && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Read uses the pre-edge memory contents, so a full push+pop on the same slot is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_do_pop;
            if (w_do_pop) r_rdata <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata   = r_rdata;
    assign o_rvalid  = r_rvalid;
    assign o_fill    = r_fill;
    assign o_push_ok = w_do_push;
endmodule

// File: rtl/dafx_host_sample_capture.sv
// Snapshots every channel's latest sample at the host rate and queues it for host pops.
// DAFX_CAPTURE_TIMESTAMP_EN adds a wrapping snapshot index returned on rd_timestamp.
module dafx_host_sample_capture
    import dafx_host_sample_capture_pkg::*;
#(
    parameter int AUDIO_WIDTH_P          = AUDIO_WIDTH_C,
    parameter int NR_OF_CHANNELS_P       = NR_OF_CHANNELS_C,
    parameter int SAMPLING_IRQ_COUNTER_P = SAMPLING_IRQ_COUNTER_C,
    parameter int FIFO_DEPTH_P           = CAPTURE_FIFO_DEPTH_C
) (
    input logic                          clk,
    input logic                          rst,
    dafx_host_sample_capture_if.slave    host_if
);
    localparam int DATA_W_L  = NR_OF_CHANNELS_P * AUDIO_WIDTH_P;
    localparam int ENTRY_W_L = DATA_W_L + CAPTURE_TS_BITS_C;
    localparam int CNT_W_L   = counter_width(SAMPLING_IRQ_COUNTER_P);
    localparam logic [CNT_W_L-1:0] CNT_LAST_L = CNT_W_L'(SAMPLING_IRQ_COUNTER_P - 1);

    logic [DATA_W_L-1:0]          r_hold;
    logic [CNT_W_L-1:0]           r_cnt;
    logic                         r_irq;
    logic                         r_overflow;
    logic                         w_tick;
    logic                         w_push_ok;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_rvalid;
    logic [ENTRY_W_L-1:0]         w_entry;
    logic [ENTRY_W_L-1:0]         w_rdata;
    logic [$clog2(FIFO_DEPTH_P):0] w_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            for (int ch = 0; ch < NR_OF_CHANNELS_P; ch++) begin
                if (host_if.x_valid[ch])
                    r_hold[ch*AUDIO_WIDTH_P +: AUDIO_WIDTH_P] <= host_if.x_data[ch*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
            end
        end
    end

    // A clear in the tick cycle wins, so the snapshot is discarded rather than pushed.
    assign w_tick = host_if.cr_enable && !host_if.cr_clear && (r_cnt == CNT_LAST_L);

    always_ff @(posedge clk) begin
        if (rst || host_if.cr_clear || !host_if.cr_enable)
            r_cnt <= '0;
        else if (r_cnt == CNT_LAST_L)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

`ifdef DAFX_CAPTURE_TIMESTAMP_EN
    logic [CAPTURE_TS_WIDTH_C-1:0] r_snap_idx;

    // Index advances on dropped ticks too, so gaps on the host side reveal overflow.
    always_ff @(posedge clk) begin
        if (rst || host_if.cr_clear)
            r_snap_idx <= '0;
        else if (w_tick)
            r_snap_idx <= r_snap_idx + 1'b1;
    end

    assign w_entry              = {r_snap_idx, r_hold};
    assign host_if.rd_timestamp = w_rdata[ENTRY_W_L-1 -: CAPTURE_TS_WIDTH_C];
`else
    assign w_entry              = r_hold;
    assign host_if.rd_timestamp = '0;
`endif

    dafx_sample_fifo #(
        .WIDTH_P (ENTRY_W_L),
        .DEPTH_P (FIFO_DEPTH_P)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (host_if.cr_clear),
        .i_push    (w_tick),
        .i_wdata   (w_entry),
        .i_pop     (host_if.cr_pop),
        .o_rdata   (w_rdata),
        .o_rvalid  (w_rvalid),
        .o_fill    (w_fill),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_push_ok (w_push_ok)
    );

    always_ff @(posedge clk) begin
        if (rst || host_if.cr_clear) begin
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_tick && !w_push_ok) r_overflow <= 1'b1;
            if (w_push_ok)
                r_irq <= 1'b1;
            else if (host_if.irq_ack)
                r_irq <= 1'b0;
        end
    end

    assign host_if.rd_data     = w_rdata[DATA_W_L-1:0];
    assign host_if.rd_valid    = w_rvalid;
    assign host_if.sr_fill     = w_fill;
    assign host_if.sr_overflow = r_overflow;
    assign host_if.irq         = r_irq;
endmodule

// File: tb/tb_dafx_host_sample_capture.sv
// Directed and randomized bench for dafx_host_sample_capture against a queue-based model.
// Honours DAFX_CAPTURE_TIMESTAMP_EN when it is defined for the build.
module tb_dafx_host_sample_capture;
    localparam int AW    = 24;
    localparam int NCH   = 2;
    localparam int CNT   = 8;
    localparam int DEPTH = 4;
    localparam int DW    = AW * NCH;
`ifdef DAFX_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dafx_host_sample_capture_if #(.AUDIO_WIDTH_P(AW), .NR_OF_CHANNELS_P(NCH), .FIFO_DEPTH_P(DEPTH)) bus ();

    dafx_host_sample_capture #(
        .AUDIO_WIDTH_P(AW), .NR_OF_CHANNELS_P(NCH),
        .SAMPLING_IRQ_COUNTER_P(CNT), .FIFO_DEPTH_P(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .host_if (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [DW-1:0] data; logic [31:0] ts; } entry_t;
    entry_t          m_q[$];
    logic [DW-1:0]   m_hold;
    int unsigned     m_en_cycles;
    logic [31:0]     m_idx;
    bit              m_irq, m_ovf, m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic [31:0]     m_rts;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: next observable state from the current inputs, using a snapshot queue.
    task automatic model_edge();
        entry_t        e;
        bit            tick, pop_ok, push_ok;
        logic [DW-1:0] snap;
        snap = m_hold;
        if (rst) begin
            m_q.delete();
            m_hold = '0; m_en_cycles = 0; m_idx = '0;
            m_irq = 0; m_ovf = 0; m_rvalid = 0; m_rdata = '0; m_rts = '0;
        end else begin
            tick   = bus.cr_enable && !bus.cr_clear && ((m_en_cycles % CNT) == CNT - 1);
            pop_ok = bus.cr_pop && !bus.cr_clear && (m_q.size() > 0);
            m_rvalid = pop_ok;
            if (pop_ok) begin
                m_rdata = m_q[0].data;
                m_rts   = m_q[0].ts;
                void'(m_q.pop_front());
            end
            if (bus.cr_clear) begin
                m_q.delete();
                m_ovf = 0; m_irq = 0; m_idx = '0; m_en_cycles = 0;
            end else begin
                push_ok = tick && (m_q.size() < DEPTH);
                if (push_ok) begin
                    e.data = snap;
                    e.ts   = TS_EN ? m_idx : 32'd0;
                    m_q.push_back(e);
                end
                if (tick && !push_ok) m_ovf = 1;
                if (tick) m_idx = m_idx + 1;
                if (push_ok) m_irq = 1;
                else if (bus.irq_ack) m_irq = 0;
                m_en_cycles = bus.cr_enable ? m_en_cycles + 1 : 0;
            end
            for (int ch = 0; ch < NCH; ch++)
                if (bus.x_valid[ch]) m_hold[ch*AW +: AW] = bus.x_data[ch*AW +: AW];
        end
    endtask

    task automatic compare_all();
        chk("cyc.rd_valid",     64'(bus.rd_valid),     64'(m_rvalid));
        chk("cyc.rd_data",      64'(bus.rd_data),      64'(m_rdata));
        chk("cyc.rd_timestamp", 64'(bus.rd_timestamp), 64'(m_rts));
        chk("cyc.sr_fill",      64'(bus.sr_fill),      64'(m_q.size()));
        chk("cyc.sr_overflow",  64'(bus.sr_overflow),  64'(m_ovf));
        chk("cyc.irq",          64'(bus.irq),          64'(m_irq));
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.x_valid = '0; bus.x_data = '0; bus.cr_enable = 1'b0;
        bus.cr_clear = 1'b0; bus.cr_pop = 1'b0; bus.irq_ack = 1'b0;
        cyc(2);
        chk("reset.fill", 64'(bus.sr_fill), 64'd0);
        chk("reset.irq", 64'(bus.irq), 64'd0);
        chk("reset.rd_data", 64'(bus.rd_data), 64'd0);
        rst = 1'b0;

        // Single snapshot, pop it back.
        bus.cr_enable = 1'b1; bus.x_valid = 2'b11; bus.x_data = {24'hFFFF00, 24'h000123};
        cyc(1);
        bus.x_valid = 2'b00;
        cyc(6);
        chk("t1.before_tick_fill", 64'(bus.sr_fill), 64'd0);
        cyc(1);
        chk("t1.fill", 64'(bus.sr_fill), 64'd1);
        chk("t1.irq", 64'(bus.irq), 64'd1);
        bus.cr_pop = 1'b1; cyc(1); bus.cr_pop = 1'b0;
        chk("t1.rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("t1.rd_data", 64'(bus.rd_data), 64'hFFFF00000123);
        chk("t1.fill_after_pop", 64'(bus.sr_fill), 64'd0);
        cyc(1);
        chk("t1.rd_valid_pulse", 64'(bus.rd_valid), 64'd0);

        // Five ticks into a depth-4 FIFO, then drain back-to-back.
        bus.cr_clear = 1'b1; cyc(1); bus.cr_clear = 1'b0;
        cyc(5 * CNT);
        chk("t2.fill", 64'(bus.sr_fill), 64'd4);
        chk("t2.overflow", 64'(bus.sr_overflow), 64'd1);
        bus.cr_enable = 1'b0; bus.cr_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t2.pop_valid", 64'(bus.rd_valid), 64'd1);
            chk("t2.pop_ts", 64'(bus.rd_timestamp), TS_EN ? 64'(i) : 64'd0);
        end
        bus.cr_pop = 1'b0;

        // Full FIFO with a pop landing exactly on the tick.
        bus.cr_clear = 1'b1; bus.cr_enable = 1'b1;
        bus.x_valid = 2'b11; bus.x_data = 48'({$urandom(), $urandom()});
        cyc(1);
        bus.cr_clear = 1'b0; bus.x_valid = 2'b00;
        cyc(4 * CNT);
        chk("t3.fill_full", 64'(bus.sr_fill), 64'd4);
        cyc(CNT - 1);
        bus.cr_pop = 1'b1; cyc(1); bus.cr_pop = 1'b0;
        chk("t3.fill_kept", 64'(bus.sr_fill), 64'd4);
        chk("t3.no_overflow", 64'(bus.sr_overflow), 64'd0);
        chk("t3.rd_valid", 64'(bus.rd_valid), 64'd1);

        // Pop on empty is ignored; ack colliding with a push leaves irq set.
        bus.cr_enable = 1'b0; bus.cr_clear = 1'b1; cyc(1); bus.cr_clear = 1'b0;
        bus.cr_pop = 1'b1; cyc(1); bus.cr_pop = 1'b0;
        chk("t4.empty_pop_valid", 64'(bus.rd_valid), 64'd0);
        chk("t4.empty_pop_data", 64'(bus.rd_data), 64'(m_rdata));
        bus.cr_enable = 1'b1;
        cyc(CNT - 1);
        bus.irq_ack = 1'b1; cyc(1); bus.irq_ack = 1'b0;
        chk("t4.ack_vs_push_irq", 64'(bus.irq), 64'd1);
        bus.irq_ack = 1'b1; cyc(1); bus.irq_ack = 1'b0;
        chk("t4.ack_clears_irq", 64'(bus.irq), 64'd0);

        // Clear with three entries pending and irq raised.
        bus.cr_clear = 1'b1; cyc(1); bus.cr_clear = 1'b0;
        cyc(3 * CNT);
        chk("t5.fill3", 64'(bus.sr_fill), 64'd3);
        chk("t5.irq_set", 64'(bus.irq), 64'd1);
        bus.cr_clear = 1'b1; cyc(1); bus.cr_clear = 1'b0;
        chk("t5.clr_fill", 64'(bus.sr_fill), 64'd0);
        chk("t5.clr_irq", 64'(bus.irq), 64'd0);
        chk("t5.clr_ovf", 64'(bus.sr_overflow), 64'd0);
        cyc(CNT - 1);
        chk("t5.no_early_push", 64'(bus.sr_fill), 64'd0);
        cyc(1);
        chk("t5.push_after_clear", 64'(bus.sr_fill), 64'd1);
        bus.cr_enable = 1'b0; bus.cr_pop = 1'b1; cyc(1); bus.cr_pop = 1'b0;
        chk("t5.ts_restart", 64'(bus.rd_timestamp), 64'd0);
        chk("t5.rd_valid", 64'(bus.rd_valid), 64'd1);

        // Reset in the middle of a count.
        bus.cr_enable = 1'b1; bus.cr_clear = 1'b1; cyc(1); bus.cr_clear = 1'b0;
        cyc(CNT + 5);
        rst = 1'b1; cyc(1);
        chk("t6.rst_fill", 64'(bus.sr_fill), 64'd0);
        chk("t6.rst_irq", 64'(bus.irq), 64'd0);
        chk("t6.rst_rd_data", 64'(bus.rd_data), 64'd0);
        chk("t6.rst_rd_ts", 64'(bus.rd_timestamp), 64'd0);
        rst = 1'b0;
        cyc(CNT - 1);
        chk("t6.no_early_tick", 64'(bus.sr_fill), 64'd0);
        cyc(1);
        chk("t6.first_tick", 64'(bus.sr_fill), 64'd1);

        // Randomized traffic with alternating pop pressure.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 499) == 0);
            bus.cr_enable = ($urandom_range(0, 19) != 0);
            bus.cr_clear  = ($urandom_range(0, 149) == 0);
            bus.cr_pop    = ((i / 400) % 2 == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            bus.irq_ack   = ($urandom_range(0, 7) == 0);
            bus.x_valid   = 2'($urandom());
            bus.x_data    = 48'({$urandom(), $urandom()});
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dafx_host_sample_capture.md
# dafx_host_sample_capture

Host-bound audio capture block for the DAFX design, the read side of the host sampling path. It snapshots the latest sample of every audio channel at the host sampling rate and queues each snapshot in a small FIFO. It raises an interrupt to the host CPU. The host drains snapshots through register-mapped pop accesses. It sits between the DSP mixer outputs and the AXI configuration register bank.

## Interface
- AUDIO_WIDTH_P, 24, signed sample width per channel
- NR_OF_CHANNELS_P, 3, channels captured per snapshot
- SAMPLING_IRQ_COUNTER_P, 12500, clock cycles per snapshot (SYS_CLK_FREQUENCY_C / HOST_F_SAMPLING_C)
- FIFO_DEPTH_P, 16, snapshot entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- x_valid  in  NR_OF_CHANNELS_P  per-channel sample strobe
- x_data  in  NR_OF_CHANNELS_P*AUDIO_WIDTH_P  per-channel samples, channel 0 in the LSBs
- cr_enable  in  1  capture enable (level)
- cr_clear  in  1  flush pulse
- cr_pop  in  1  host pop pulse
- irq_ack  in  1  host interrupt acknowledge pulse
- rd_data  out  NR_OF_CHANNELS_P*AUDIO_WIDTH_P  popped snapshot
- rd_timestamp  out  32  popped snapshot index (see Configuration)
- rd_valid  out  1  one-cycle pulse: rd_data/rd_timestamp updated
- sr_fill  out  $clog2(FIFO_DEPTH_P)+1  entries in FIFO
- sr_overflow  out  1  sticky: snapshot dropped on full
- irq  out  1  level interrupt

## Operation
- **Hold registers:** one per channel; loaded from its x_data slice when x_valid[i]=1; reset to 0. They are never cleared by cr_clear.
- **Tick counter:** counts 0..SAMPLING_IRQ_COUNTER_P-1 and wraps while cr_enable=1.
  - While cr_enable=0 the counter is held at 0. FIFO contents are retained.
  - Tick occurs when counter == SAMPLING_IRQ_COUNTER_P-1 and cr_enable=1.
- **Push on tick:** the hold registers are concatenated and pushed.
  - If x_valid coincides with a tick, the old hold value is pushed; the new value is taken at the next tick.
- **Full with no simultaneous pop:** the snapshot is dropped and sr_overflow is set. sr_fill is unchanged.
- **Pop:** cr_pop with sr_fill>0 reads the head entry. cr_pop while empty is ignored (no rd_valid, no state change).
- **Simultaneous push and pop:**
  - Full: both succeed; sr_fill unchanged; no overflow.
  - Empty: the pop is ignored and the push succeeds.
- **irq:** set on every successful push; cleared by irq_ack. If a push and irq_ack occur in the same cycle, set wins (irq stays 1).
- **cr_clear priority:** highest of all controls. It resets the counter, empties the FIFO, clears sr_overflow and irq, and resets the snapshot index. A tick in the same cycle is discarded.

## Timing
- **Reset values:** rd_data=0, rd_timestamp=0, rd_valid=0, sr_fill=0, sr_overflow=0, irq=0; counter=0, FIFO pointers=0.
- **First tick:** occurs SAMPLING_IRQ_COUNTER_P cycles after cr_enable rises.
- **Push latency:** the FIFO write, sr_fill increment and irq all register on the clock edge ending the tick cycle; all are visible the next cycle.
- **Pop latency:** rd_data/rd_timestamp are registered and rd_valid pulses one cycle after cr_pop. sr_fill decrements in that same cycle.
- **Between pops:** rd_data holds its value.
- **Back-to-back pops:** allowed every cycle.
- **Pointers:** wrap modulo FIFO_DEPTH_P. Full/empty are decided from sr_fill, not pointer compare.
- **Mid-operation reset:** rst during any state returns all registers to reset values on the next edge. No partial pops.

## Configuration
- DAFX_CAPTURE_TIMESTAMP_EN defined:
  - A 32-bit snapshot index increments (wrapping) on every tick, including dropped ones. It is reset by rst and cr_clear.
  - Each FIFO entry stores the index value at push time; rd_timestamp returns it.
  - Gaps in the index expose drops.
- DAFX_CAPTURE_TIMESTAMP_EN undefined: no index register and no extra FIFO width; rd_timestamp is tied to 0.

## Structure
- Shared package:
  - Localparams CAPTURE_FIFO_DEPTH_C=16, CAPTURE_TS_WIDTH_C=32.
  - Typedef of the snapshot word: NR_OF_CHANNELS_C×AUDIO_WIDTH_C plus optional timestamp.
  - Defaults reuse AUDIO_WIDTH_C, NR_OF_CHANNELS_C, SAMPLING_IRQ_COUNTER_C.
- One sub-module, dafx_sample_fifo: synchronous FIFO with registered read, fill count, and full/empty flags. Width and depth are parameters.

## Test plan
Bench settings: SAMPLING_IRQ_COUNTER_P=8, FIFO_DEPTH_P=4, 2 channels.
- Enable, x_data ch0=0x000123/ch1=0xFFFF00 → push at cycle 8 after enable; irq=1; pop → rd_data={0xFFFF00,0x000123} one cycle later with rd_valid; sr_fill 1→0.
- 5 ticks without pops → sr_fill=4, sr_overflow=1; with macro, pops return timestamps 0,1,2,3.
- Full FIFO, cr_pop exactly on the tick cycle → sr_fill stays 4; sr_overflow remains 0 (fresh clear beforehand).
- cr_pop while empty → no rd_valid; rd_data unchanged. irq_ack in the same cycle as a push → irq stays 1.
- cr_clear with 3 entries and irq=1 → sr_fill=0, irq=0, sr_overflow=0; next push arrives 8 cycles later with timestamp 0.
- rst mid-count at counter=5 with cr_enable=1 → all outputs 0; first tick 8 cycles after rst drops.
